// File: rtl/mips_pkg.sv
// Constants shared by the control unit and the I/O port.
// The helper decodes which way an I/O instruction moves data.
package mips_pkg;

  localparam int          DATA_W      = 16;
  localparam logic [3:0]  OP_IO       = 4'b1100;
  localparam logic [2:0]  FUNK_IN     = 3'd1;
  localparam logic [1:0]  MEMTOREG_IO = 2'b10;

  typedef enum logic {
    IO_OUT = 1'b0,
    IO_IN  = 1'b1
  } io_dir_e;

  function automatic io_dir_e io_dir(input logic [2:0] funk);
    return (funk == FUNK_IN) ? IO_IN : IO_OUT;
  endfunction

endpackage

// File: rtl/mips_io_port_if.sv
// Device-side valid/ready streams of the I/O port.
// The master modport is the port itself; the slave modport is the external device.
interface mips_io_port_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    input  in_data,
    input  in_valid,
    output in_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    output in_data,
    output in_valid,
    input  in_ready
  );

endinterface

// File: rtl/mips_io_port_fifo.sv
// Power-of-two circular FIFO with registered occupancy; a push into a full
// FIFO is refused even when a pop happens in the same cycle.
module io_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[head];

  // Storage is cleared on reset so the head reads as zero until written.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// I/O responder for the multicycle core: buffers OUT data to a device and
// IN data from it, stalling the core on a full output or empty input FIFO.
module mips_io_port
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 2
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       OutputWrite,
  input  logic [DATA_W-1:0]          OutData,
  input  logic                       InputRead,
  output logic [DATA_W-1:0]          InData,
  output logic                       IOStall,
  mips_io_port_if.master             dev,
  output logic [$clog2(OUT_DEPTH):0] out_count,
  output logic [$clog2(IN_DEPTH):0]  in_count
);

  logic out_full;
  logic out_empty;
  logic in_full;
  logic in_empty;
  logic out_push;
  logic out_pop;
  logic in_push;

  // InputRead wins if the core ever asserts both strobes.
  assign out_push      = OutputWrite && !InputRead;
  assign out_pop       = dev.out_valid && dev.out_ready;
  assign dev.out_valid = !out_empty;
  assign dev.in_ready  = !in_full;
  assign in_push       = dev.in_valid && dev.in_ready;

  assign IOStall = !Reset &&
                   ((OutputWrite && (out_full || InputRead)) ||
                    (InputRead && in_empty));

  io_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (OutData),
    .rdata (dev.out_data),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  io_fifo #(
    .DEPTH (IN_DEPTH),
    .WIDTH (DATA_W)
  ) u_in_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (in_push),
    .pop   (InputRead),
    .wdata (dev.in_data),
    .rdata (InData),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

endmodule
